// File: rtl/axis_noc_injector.sv
// axis_noc_injector: round-robin AXI-Stream to NoC flit injector with per-packet grant lock
// and downstream credit flow control. Statistics counters are built when AXIS_NOC_INJECTOR_STATS_EN is defined.
module axis_noc_injector #(
    parameter int NUM_CHANNELS      = 4,
    parameter int TDATA_WIDTH       = 128,
    parameter int TID_WIDTH         = 2,
    parameter int TDEST_WIDTH       = 4,
    parameter int DEST_WIDTH        = TDEST_WIDTH + TID_WIDTH,
    parameter int FLIT_BUFFER_DEPTH = 8,
    parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1),
    localparam int CH_W             = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                    clk_noc,
    input  logic                                    rst_n,
    input  logic [NUM_CHANNELS-1:0]                 axis_in_tvalid,
    output logic [NUM_CHANNELS-1:0]                 axis_in_tready,
    input  logic [NUM_CHANNELS-1:0][TDATA_WIDTH-1:0] axis_in_tdata,
    input  logic [NUM_CHANNELS-1:0]                 axis_in_tlast,
    input  logic [NUM_CHANNELS-1:0][TID_WIDTH-1:0]  axis_in_tid,
    input  logic [NUM_CHANNELS-1:0][TDEST_WIDTH-1:0] axis_in_tdest,
    output logic [TDATA_WIDTH-1:0]                  data_out,
    output logic [DEST_WIDTH-1:0]                   dest_out,
    output logic                                    is_tail_out,
    output logic                                    send_out,
    input  logic                                    credit_in,
    output logic [CREDIT_WIDTH-1:0]                 credit_count,
    output logic [CH_W-1:0]                         active_channel,
    output logic                                    credit_err,
    output logic [31:0]                             flit_count,
    output logic [31:0]                             pkt_count
);

    // state  | meaning
    // IDLE   | no packet in flight; round-robin search from r_rr_ptr picks the grant
    // LOCKED | head beat accepted from r_lock_ch; only that channel is served until its tail
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [CH_W-1:0]         LAST_CH    = CH_W'(NUM_CHANNELS - 1);

    state_t                  r_state;
    logic [CH_W-1:0]         r_rr_ptr;
    logic [CH_W-1:0]         r_lock_ch;
    logic [CREDIT_WIDTH-1:0] r_credit;
    logic                    r_credit_err;
    logic [TDATA_WIDTH-1:0]  r_data;
    logic [DEST_WIDTH-1:0]   r_dest;
    logic                    r_tail;
    logic                    r_send;

    logic [CH_W-1:0] w_grant;
    logic [CH_W-1:0] w_idx;
    logic [CH_W-1:0] w_sel;
    logic [CH_W-1:0] w_next_ptr;
    logic            w_any_valid;
    logic            w_sel_valid;
    logic            w_credit_ok;
    logic            w_accept;

    // Walk offsets from the highest down so the lowest offset from r_rr_ptr wins.
    always_comb begin
        w_grant     = r_rr_ptr;
        w_any_valid = 1'b0;
        w_idx       = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            w_idx = CH_W'((int'(r_rr_ptr) + i) % NUM_CHANNELS);
            if (axis_in_tvalid[w_idx]) begin
                w_grant     = w_idx;
                w_any_valid = 1'b1;
            end
        end
    end

    assign w_sel       = (r_state == LOCKED) ? r_lock_ch : w_grant;
    assign w_sel_valid = (r_state == LOCKED) ? axis_in_tvalid[r_lock_ch] : w_any_valid;
    assign w_credit_ok = (r_credit != '0);
    assign w_accept    = w_credit_ok && w_sel_valid;
    assign w_next_ptr  = (w_sel == LAST_CH) ? '0 : w_sel + 1'b1;

    always_comb begin
        axis_in_tready = '0;
        if (w_accept) begin
            axis_in_tready[w_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rr_ptr  <= '0;
            r_lock_ch <= '0;
        end else if (w_accept) begin
            if (axis_in_tlast[w_sel]) begin
                r_state  <= IDLE;
                r_rr_ptr <= w_next_ptr;
            end else begin
                r_state   <= LOCKED;
                r_lock_ch <= w_sel;
            end
        end
    end

    // A credit returned into an already full counter is a protocol error downstream.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            r_credit     <= CREDIT_MAX;
            r_credit_err <= 1'b0;
        end else if (w_accept && !credit_in) begin
            r_credit <= r_credit - 1'b1;
        end else if (credit_in && !w_accept) begin
            if (r_credit == CREDIT_MAX) begin
                r_credit_err <= 1'b1;
            end else begin
                r_credit <= r_credit + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            r_send <= 1'b0;
            r_tail <= 1'b0;
            r_data <= '0;
            r_dest <= '0;
        end else begin
            r_send <= w_accept;
            if (w_accept) begin
                r_data <= axis_in_tdata[w_sel];
                r_dest <= {axis_in_tid[w_sel], axis_in_tdest[w_sel]};
                r_tail <= axis_in_tlast[w_sel];
            end
        end
    end

`ifdef AXIS_NOC_INJECTOR_STATS_EN
    logic [31:0] r_flit_count;
    logic [31:0] r_pkt_count;

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            r_flit_count <= '0;
            r_pkt_count  <= '0;
        end else if (r_send) begin
            r_flit_count <= r_flit_count + 32'd1;
            if (r_tail) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
        end
    end

    assign flit_count = r_flit_count;
    assign pkt_count  = r_pkt_count;
`else
    assign flit_count = 32'd0;
    assign pkt_count  = 32'd0;
`endif

    assign data_out       = r_data;
    assign dest_out       = r_dest;
    assign is_tail_out    = r_tail;
    assign send_out       = r_send;
    assign credit_count   = r_credit;
    assign credit_err     = r_credit_err;
    assign active_channel = w_sel;

endmodule

// File: tb/tb_axis_noc_injector.sv
// Testbench for axis_noc_injector: directed protocol steps followed by randomized multi-channel
// streams checked against a packet-level round-robin reference model.
`timescale 1ns/1ps
module tb_axis_noc_injector;

    localparam int NCH = 4, DW = 128, IDW = 2, TDW = 4, DSTW = 6, DEPTH = 8, CW = 4, AW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NCH-1:0]          tvalid, tready, tlast;
    logic [NCH-1:0][DW-1:0]  tdata;
    logic [NCH-1:0][IDW-1:0] tid;
    logic [NCH-1:0][TDW-1:0] tdest;
    logic [DW-1:0]   data_out;
    logic [DSTW-1:0] dest_out;
    logic            is_tail_out, send_out, credit_in, credit_err;
    logic [CW-1:0]   credit_count;
    logic [AW-1:0]   active_channel;
    logic [31:0]     flit_count, pkt_count;

    axis_noc_injector dut (
        .clk_noc(clk), .rst_n(rst_n),
        .axis_in_tvalid(tvalid), .axis_in_tready(tready), .axis_in_tdata(tdata),
        .axis_in_tlast(tlast), .axis_in_tid(tid), .axis_in_tdest(tdest),
        .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
        .send_out(send_out), .credit_in(credit_in), .credit_count(credit_count),
        .active_channel(active_channel), .credit_err(credit_err),
        .flit_count(flit_count), .pkt_count(pkt_count)
    );

    typedef struct packed {
        logic [DW-1:0]  data;
        logic           last;
        logic [IDW-1:0] id;
        logic [TDW-1:0] dst;
    } beat_t;

    beat_t src_q [NCH][$];
    beat_t tmp_q [NCH][$];
    beat_t exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic clr_inputs();
        tvalid = '0; tlast = '0; tdata = '0; tid = '0; tdest = '0;
    endtask

    task automatic set_beat(input int ch, input logic [DW-1:0] d, input logic l,
                            input logic [IDW-1:0] i, input logic [TDW-1:0] t);
        tvalid[ch] = 1'b1; tdata[ch] = d; tlast[ch] = l; tid[ch] = i; tdest[ch] = t;
    endtask

    task automatic do_reset();
        clr_inputs();
        credit_in = 1'b0;
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic give_credits(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) credit_in = 1'b1;
        end
        @(negedge clk) credit_in = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic add_pkt(input int ch, input int len);
        beat_t b;
        b.id  = IDW'($urandom_range(0, 3));
        b.dst = TDW'($urandom_range(0, 15));
        for (int k = 0; k < len; k++) begin
            b.data = rnd128();
            b.last = (k == len - 1);
            src_q[ch].push_back(b);
        end
    endtask

    // Expected flit order: whole packets, next packet from the first channel after the last served
    // one (cyclically) that still has data. Valid only when all sources are backlogged from reset.
    task automatic build_expect();
        int    ptr;
        int    c;
        beat_t b;
        ptr = 0;
        exp_q.delete();
        for (int i = 0; i < NCH; i++) tmp_q[i] = src_q[i];
        for (int guard = 0; guard < 1000; guard++) begin
            c = -1;
            for (int i = 0; i < NCH; i++)
                if (c < 0 && tmp_q[(ptr + i) % NCH].size() > 0) c = (ptr + i) % NCH;
            if (c < 0) break;
            do begin
                b = tmp_q[c].pop_front();
                exp_q.push_back(b);
            end while (!b.last);
            ptr = (c + 1) % NCH;
        end
    endtask

    task automatic run_stream(input int max_cycles, input int credit_pct);
        int    outstanding, cred_model, got, total, acc;
        beat_t e, b;
        build_expect();
        outstanding = 0; cred_model = DEPTH; got = 0; total = exp_q.size();
        for (int cyc = 0; cyc < max_cycles && (got < total || outstanding > 0); cyc++) begin
            @(negedge clk);
            if (send_out) begin
                if (exp_q.size() == 0) begin
                    chk("extra_flit", 128'(exp_q.size()), 128'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rs_data", data_out, e.data);
                    chk("rs_dest", dest_out, {e.id, e.dst});
                    chk("rs_tail", is_tail_out, e.last);
                end
                got++;
                outstanding++;
            end
            chk("rs_credit", credit_count, 128'(cred_model));
            credit_in = (outstanding > 0) && ($urandom_range(0, 99) < credit_pct);
            if (credit_in) outstanding--;
            for (int c = 0; c < NCH; c++) begin
                if (src_q[c].size() > 0) begin
                    b = src_q[c][0];
                    tvalid[c] = 1'b1; tdata[c] = b.data; tlast[c] = b.last;
                    tid[c] = b.id; tdest[c] = b.dst;
                end else begin
                    tvalid[c] = 1'b0; tlast[c] = 1'b0;
                end
            end
            #1;
            acc = 0;
            for (int c = 0; c < NCH; c++) begin
                if (tvalid[c] && tready[c]) begin
                    void'(src_q[c].pop_front());
                    acc++;
                end
            end
            if (acc > 1) chk("rs_onehot", 128'(acc), 128'd1);
            if (cred_model == 0) chk("rs_no_credit_accept", 128'(acc), 128'd0);
            cred_model = cred_model - acc + int'(credit_in);
        end
        @(negedge clk);
        credit_in = 1'b0;
        clr_inputs();
        chk("rs_all_flits", 128'(got), 128'(total));
        chk("rs_exp_empty", 128'(exp_q.size()), 128'd0);
        @(negedge clk);
        chk("rs_credit_final", credit_count, 128'(DEPTH));
    endtask

    logic [DW-1:0] d [4];
    int acc_cnt;
    int total_flits, total_pkts;

    initial begin
        for (int i = 0; i < 4; i++) d[i] = rnd128();
        credit_in = 1'b0;
        clr_inputs();

        // Reset values
        do_reset();
        chk("rst_send", send_out, 0);
        chk("rst_tready", tready, 0);
        chk("rst_credit", credit_count, DEPTH);
        chk("rst_err", credit_err, 0);
        chk("rst_active", active_channel, 0);
        chk("rst_data", data_out, 0);
        chk("rst_dest", dest_out, 0);
        chk("rst_tail", is_tail_out, 0);
        chk("rst_flits", flit_count, 0);
        chk("rst_pkts", pkt_count, 0);

        // 3-beat packet on channel 2, tid 1 tdest 5
        @(negedge clk); set_beat(2, d[0], 1'b0, 2'd1, 4'd5);
        #1 chk("t1_ready", tready, 4'b0100);
        @(negedge clk);
        chk("t1_send0", send_out, 1); chk("t1_data0", data_out, d[0]);
        chk("t1_dest", dest_out, 6'h15); chk("t1_tail0", is_tail_out, 0);
        chk("t1_active", active_channel, 2);
        set_beat(2, d[1], 1'b0, 2'd1, 4'd5);
        @(negedge clk);
        chk("t1_send1", send_out, 1); chk("t1_data1", data_out, d[1]); chk("t1_tail1", is_tail_out, 0);
        set_beat(2, d[2], 1'b1, 2'd1, 4'd5);
        @(negedge clk);
        chk("t1_send2", send_out, 1); chk("t1_data2", data_out, d[2]); chk("t1_tail2", is_tail_out, 1);
        chk("t1_credit", credit_count, 5);
        clr_inputs();
        @(negedge clk);
        chk("t1_idle", send_out, 0);
        give_credits(3);
        chk("t1_refill", credit_count, DEPTH);

        // Channels 0 and 1 compete with 2-beat packets; grant stays locked on channel 0
        @(negedge clk);
        set_beat(0, d[0], 1'b0, 2'd0, 4'd1);
        set_beat(1, d[1], 1'b0, 2'd0, 4'd2);
        #1 chk("t2_ready_a", tready, 4'b0001);
        @(negedge clk);
        chk("t2_data0", data_out, d[0]);
        set_beat(0, d[2], 1'b1, 2'd0, 4'd1);
        #1 chk("t2_lock", tready, 4'b0001); chk("t2_active", active_channel, 0);
        @(negedge clk);
        chk("t2_data1", data_out, d[2]); chk("t2_tail1", is_tail_out, 1);
        tvalid[0] = 1'b0;
        #1 chk("t2_ready_b", tready, 4'b0010);
        @(negedge clk);
        chk("t2_data2", data_out, d[1]); chk("t2_dest2", dest_out, 6'h02); chk("t2_send_b2b", send_out, 1);
        set_beat(1, d[3], 1'b1, 2'd0, 4'd2);
        @(negedge clk);
        chk("t2_data3", data_out, d[3]); chk("t2_tail3", is_tail_out, 1);
        clr_inputs();
        set_beat(0, d[0], 1'b1, 2'd0, 4'd0);
        set_beat(2, d[1], 1'b1, 2'd0, 4'd0);
        set_beat(3, d[2], 1'b1, 2'd0, 4'd0);
        #1 chk("t2_rrptr", active_channel, 2); chk("t2_rr_ready", tready, 4'b0100);
        clr_inputs();
        give_credits(4);
        chk("t2_refill", credit_count, DEPTH);

        // Credit exhaustion with 10 single-flit packets offered on channel 0
        acc_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); set_beat(0, DW'(k), 1'b1, 2'd0, 4'd3);
            #1 if (tready[0]) acc_cnt++;
        end
        chk("t3_accepted", acc_cnt, 8);
        chk("t3_stall", tready, 0);
        chk("t3_credit0", credit_count, 0);
        @(negedge clk); credit_in = 1'b1;
        #1 chk("t3_no_same_cycle", tready, 0);
        @(negedge clk); credit_in = 1'b0;
        #1 chk("t3_one_more", tready, 4'b0001); chk("t3_credit1", credit_count, 1);
        @(negedge clk);
        #1 chk("t3_stall_again", tready, 0); chk("t3_send", send_out, 1);
        clr_inputs();

        // Simultaneous credit and beat; overflow flag
        give_credits(3);
        chk("t4_credit3", credit_count, 3);
        @(negedge clk); set_beat(0, d[0], 1'b1, 2'd0, 4'd0); credit_in = 1'b1;
        #1 chk("t4_ready", tready, 4'b0001);
        @(negedge clk); clr_inputs(); credit_in = 1'b0;
        chk("t4_simul", credit_count, 3);
        give_credits(5);
        chk("t4_full", credit_count, DEPTH); chk("t4_err0", credit_err, 0);
        @(negedge clk) credit_in = 1'b1;
        @(negedge clk) credit_in = 1'b0;
        chk("t4_sat", credit_count, DEPTH); chk("t4_err1", credit_err, 1);
        @(negedge clk);
        chk("t4_err_sticky", credit_err, 1);

        // Reset in the middle of a 4-beat packet
        @(negedge clk); set_beat(1, d[0], 1'b0, 2'd0, 4'd4);
        @(negedge clk); set_beat(1, d[1], 1'b0, 2'd0, 4'd4);
        @(negedge clk);
        rst_n = 1'b0; clr_inputs();
        #1 chk("t5_send", send_out, 0); chk("t5_credit", credit_count, DEPTH);
        chk("t5_err", credit_err, 0); chk("t5_tready", tready, 0);
        @(negedge clk); rst_n = 1'b1;
        set_beat(3, d[2], 1'b1, 2'd2, 4'd9);
        #1 chk("t5_grant3", tready, 4'b1000); chk("t5_active3", active_channel, 3);
        @(negedge clk);
        chk("t5_send3", send_out, 1); chk("t5_data3", data_out, d[2]); chk("t5_dest3", dest_out, 6'h29);
        clr_inputs();

        // Statistics: 5 packets of 4 beats
        do_reset();
        for (int p = 0; p < 5; p++) add_pkt((p * 3) % NCH, 4);
        run_stream(1000, 70);
`ifdef AXIS_NOC_INJECTOR_STATS_EN
        chk("st_flits", flit_count, 20);
        chk("st_pkts", pkt_count, 5);
`else
        chk("st_flits", flit_count, 0);
        chk("st_pkts", pkt_count, 0);
`endif

        // Randomized backlogged streams on all channels with random credit return
        for (int round = 0; round < 3; round++) begin
            do_reset();
            total_flits = 0; total_pkts = 0;
            for (int c = 0; c < NCH; c++) begin
                int np;
                np = $urandom_range(1, 5);
                for (int p = 0; p < np; p++) begin
                    int len;
                    len = $urandom_range(1, 5);
                    add_pkt(c, len);
                    total_flits += len;
                    total_pkts++;
                end
            end
            run_stream(3000, 20 + 30 * round);
`ifdef AXIS_NOC_INJECTOR_STATS_EN
            chk("rnd_flits", flit_count, 128'(total_flits));
            chk("rnd_pkts", pkt_count, 128'(total_pkts));
`else
            chk("rnd_flits", flit_count, 0);
            chk("rnd_pkts", pkt_count, 0);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
